// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: accepts an operand pair over valid/ready, adds it
// LSB-first through a single full-adder cell, and returns sum/carry over valid/ready.

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum_c,
    output logic carry_c
);
    assign sum_c   = a ^ b;
    assign carry_c = a & b;
endmodule

module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             busy
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_nxt_c;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;

    logic accept_c;
    logic last_bit_c;
    logic ha0_sum_c;
    logic ha0_carry_c;
    logic cell_sum_c;
    logic ha1_carry_c;
    logic cell_carry_c;

    // Single full-adder cell shared by every bit position
    half_adder u_ha0 (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .sum_c   (ha0_sum_c),
        .carry_c (ha0_carry_c)
    );

    half_adder u_ha1 (
        .a       (ha0_sum_c),
        .b       (carry_reg),
        .sum_c   (cell_sum_c),
        .carry_c (ha1_carry_c)
    );

    assign cell_carry_c = ha0_carry_c | ha1_carry_c;
    assign sum_sh_nxt_c = {cell_sum_c, sum_sh[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        accept_c   = 1'b0;
        last_bit_c = 1'b0;
        case (state)
            IDLE: begin
                accept_c = in_valid && in_ready;
                if (accept_c) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                last_bit_c = (cnt == CNT_LAST);
                if (last_bit_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake/status flags follow the upcoming state so they are pure registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == RUN);
        end
    end

    // Operand shifting, carry chain through time, and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            cout      <= 1'b0;
        end else if (accept_c) begin
            a_sh      <= a_in;
            b_sh      <= b_in;
            carry_reg <= cin;
            cnt       <= '0;
        end else if (state == RUN) begin
            a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh    <= sum_sh_nxt_c;
            carry_reg <= cell_carry_c;
            cnt       <= cnt + CNT_W'(1);
            if (last_bit_c) begin
                sum_out <= sum_sh_nxt_c;
                cout    <= cell_carry_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed cases at WIDTH=8 and
// randomised traffic at WIDTH=2 and WIDTH=16 against an arithmetic reference.

module tb_serial_add_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic       iv8, ir8, ov8, or8, cin8, co8, busy8;
    logic [7:0] a8, b8, s8;

    logic        sel16, r_iv, r_or, r_cin;
    logic [15:0] r_a, r_b;
    logic        ir2, ov2, co2, busy2;
    logic [1:0]  s2;
    logic        ir16, ov16, co16, busy16;
    logic [15:0] s16;
    logic        r_ir, r_ov, r_co;
    logic [15:0] r_sum;

    int unsigned exp_q[$];
    bit          abort;

    assign r_ir  = sel16 ? ir16 : ir2;
    assign r_ov  = sel16 ? ov16 : ov2;
    assign r_co  = sel16 ? co16 : co2;
    assign r_sum = sel16 ? s16 : {14'b0, s2};

    serial_add_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum_out(s8), .cout(co8), .busy(busy8)
    );

    serial_add_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(r_iv && !sel16), .in_ready(ir2), .a_in(r_a[1:0]),
        .b_in(r_b[1:0]), .cin(r_cin), .out_valid(ov2), .out_ready(r_or && !sel16),
        .sum_out(s2), .cout(co2), .busy(busy2)
    );

    serial_add_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(r_iv && sel16), .in_ready(ir16), .a_in(r_a),
        .b_in(r_b), .cin(r_cin), .out_valid(ov16), .out_ready(r_or && sel16),
        .sum_out(s16), .cout(co16), .busy(busy16)
    );

    // Present one operand pair on the WIDTH=8 instance and wait for its result
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output logic [7:0] s, output logic co, output int lat,
                          output logic busy_first, output logic ir_first);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1; or8 = 1'b0;
        for (int i = 0; i < 50 && !ir8; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        busy_first = busy8;
        ir_first = ir8;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s = s8;
        co = co8;
    endtask

    task automatic release8();
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if ({co8, s8} !== 9'h000) begin errors++; $display("FAIL reset_result got %h want 000", {co8, s8}); end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({ir8, ov8, busy8} !== 3'b100) begin
            errors++; $display("FAIL midrun_reset_flags got %b want 100", {ir8, ov8, busy8});
        end
        or8 = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ov8) seen = 1'b1;
        end
        or8 = 1'b0;
        checks++; if (seen) begin errors++; $display("FAIL midrun_result_leak got out_valid=1 want none"); end
    endtask

    task automatic test_latency();
        logic [7:0] s; logic co, bf, irf; int lat;
        run_op(8'h35, 8'h0A, 1'b0, s, co, lat, bf, irf);
        checks++; if (lat != 8) begin errors++; $display("FAIL latency got %0d want 8", lat); end
        checks++; if ({bf, irf} !== 2'b10) begin errors++; $display("FAIL run_flags got %b want 10", {bf, irf}); end
        checks++; if ({co, s} !== 9'h03F) begin errors++; $display("FAIL sum_35_0a got %h want 03f", {co, s}); end
        release8();
        checks++; if ({ov8, ir8} !== 2'b01) begin errors++; $display("FAIL post_handshake got %b want 01", {ov8, ir8}); end
        checks++; if ({co8, s8} !== 9'h03F) begin errors++; $display("FAIL result_hold got %h want 03f", {co8, s8}); end
    endtask

    task automatic test_carry();
        logic [7:0] s; logic co, bf, irf; int lat;
        run_op(8'hFF, 8'h01, 1'b0, s, co, lat, bf, irf);
        checks++; if ({co, s} !== 9'h100) begin errors++; $display("FAIL ripple_ff_01 got %h want 100", {co, s}); end
        release8();
        run_op(8'hFF, 8'hFF, 1'b1, s, co, lat, bf, irf);
        checks++; if ({co, s} !== 9'h1FF) begin errors++; $display("FAIL ripple_ff_ff_c got %h want 1ff", {co, s}); end
        release8();
    endtask

    task automatic test_stall();
        logic [7:0] s; logic co, bf, irf; int lat; bit seen;
        run_op(8'h12, 8'h34, 1'b1, s, co, lat, bf, irf);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ov8, ir8, co8, s8} !== {1'b1, 1'b0, 1'b0, 8'h47}) begin
                errors++; $display("FAIL stall_hold cycle %0d got %b%b%b_%h want 100_47", i, ov8, ir8, co8, s8);
            end
        end
        iv8 = 1'b0;
        release8();
        checks++; if ({ov8, ir8} !== 2'b01) begin errors++; $display("FAIL stall_release got %b want 01", {ov8, ir8}); end
        seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (ov8 || busy8) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL stall_queued got activity want idle"); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [2];
        logic [7:0] tb [2];
        logic [7:0] rs [2];
        logic       rc [2];
        int acc [2];
        int k = 0, r = 0;
        bit upd = 1'b0;
        ta[0] = 8'h01; tb[0] = 8'h01; ta[1] = 8'h80; tb[1] = 8'h80;
        @(negedge clk);
        a8 = ta[0]; b8 = tb[0]; cin8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        for (int cyc = 0; cyc < 60 && r < 2; cyc++) begin
            if (upd) begin
                upd = 1'b0;
                if (k < 2) begin a8 = ta[k]; b8 = tb[k]; end
                else iv8 = 1'b0;
            end
            if (ov8 && or8) begin rs[r] = s8; rc[r] = co8; r++; end
            if (iv8 && ir8 && k < 2) begin acc[k] = cyc; k++; upd = 1'b1; end
            @(negedge clk);
        end
        iv8 = 1'b0; or8 = 1'b0;
        checks++;
        if (k != 2 || r != 2) begin
            errors++; $display("FAIL b2b_count got accepts=%0d results=%0d want 2/2", k, r);
        end else begin
            checks++; if (acc[1] - acc[0] != 10) begin errors++; $display("FAIL b2b_spacing got %0d want 10", acc[1] - acc[0]); end
            checks++; if ({rc[0], rs[0]} !== 9'h002) begin errors++; $display("FAIL b2b_first got %h want 002", {rc[0], rs[0]}); end
            checks++; if ({rc[1], rs[1]} !== 9'h100) begin errors++; $display("FAIL b2b_second got %h want 100", {rc[1], rs[1]}); end
        end
    endtask

    task automatic test_random(input logic sel, input int w, input int n);
        int unsigned mask;
        mask = (32'd1 << w) - 1;
        sel16 = sel;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        fork
            begin : producer
                for (int i = 0; i < n && !abort; i++) begin
                    int wt;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    r_a = 16'($urandom & mask);
                    r_b = 16'($urandom & mask);
                    r_cin = 1'($urandom_range(0, 1));
                    r_iv = 1'b1;
                    wt = 0;
                    while (!r_ir && wt < 200) begin @(negedge clk); wt++; end
                    if (!r_ir) begin
                        checks++; errors++; abort = 1'b1;
                        $display("FAIL rand_w%0d_accept_timeout got in_ready=0 want 1", w);
                    end else begin
                        exp_q.push_back(32'(r_a) + 32'(r_b) + 32'(r_cin));
                        @(negedge clk);
                    end
                    r_iv = 1'b0;
                end
            end
            begin : consumer
                int got = 0, cyc = 0;
                while (got < n && cyc < n * 40 && !abort) begin
                    r_or = ($urandom_range(0, 3) != 0);
                    if (r_ov && r_or) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_w%0d_spurious got result %h want none", w, r_sum);
                        end else begin
                            int unsigned e;
                            e = exp_q.pop_front();
                            if (r_sum !== 16'(e & mask) || r_co !== 1'(e >> w)) begin
                                errors++;
                                $display("FAIL rand_w%0d_result op %0d got %b_%h want %b_%h", w, got,
                                         r_co, r_sum, 1'(e >> w), 16'(e & mask));
                            end
                        end
                        got++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                if (got < n && !abort) begin
                    checks++; errors++; abort = 1'b1;
                    $display("FAIL rand_w%0d_timeout got %0d results want %0d", w, got, n);
                end
                r_or = 1'b0;
            end
        join
        r_iv = 1'b0;
        r_or = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        sel16 = 1'b0; r_iv = 1'b0; r_or = 1'b0; r_cin = 1'b0; r_a = '0; r_b = '0;
        test_reset();
        test_reset_mid_run();
        test_latency();
        test_carry();
        test_stall();
        test_back_to_back();
        test_random(1'b0, 2, 1000);
        test_random(1'b1, 16, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
